// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity selection and the
// parity helper used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Parity bit that accompanies 'data' on the line.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, byte/strobe/status out, plus the
// receiver state for observation.
interface uart_rx_if;
    import uart_pkg::*;

    // data_strobe is a one-cycle valid with no ready: the sink must take dout
    // and rx_error in the strobe cycle; both hold until the next strobe.
    logic       rx_in;
    logic [7:0] dout;
    logic       data_strobe;
    logic       busy;
    logic       rx_error;
    rx_state_t  state;

    modport master (
        input  rx_in,
        output dout, data_strobe, busy, rx_error, state
    );

    modport slave (
        output rx_in,
        input  dout, data_strobe, busy, rx_error, state
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; RST_VAL is the
// value both flops take in reset (1 for an idle UART line).
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits LSB first, 1 parity, 1 stop. Bits are
// sampled at mid-bit from a free-running baud counter re-aligned on the start bit.
module uart_rx #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200,
    parameter int PARITY        = 0
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master rx
);
    import uart_pkg::*;

    localparam int BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
    localparam int HALF_BAUD   = BAUD_CLOCKS / 2;
    localparam int CNT_W       = $clog2(BAUD_CLOCKS);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CLOCKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BAUD - 1);
    localparam logic ODD = (PARITY != 0) ? PARITY_ODD : PARITY_EVEN;

    logic             rx_s;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       dout_q, dout_d;
    logic             par_err_q, par_err_d;
    logic             strobe_q, strobe_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx.rx_in),
        .q   (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        dout_d    = dout_q;
        par_err_d = par_err_q;
        strobe_d  = 1'b0;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s) state_d = START;
            end
            // A line that is high again at mid start bit was only a glitch.
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx_s;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = uart_pkg::PARITY;
                end
            end
            uart_pkg::PARITY: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d     = '0;
                    par_err_d = (rx_s != parity_bit(shift_q, ODD));
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d    = '0;
                    dout_d   = shift_q;
                    strobe_d = 1'b1;
                    err_d    = par_err_q | ~rx_s;
                    state_d  = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            // Hold off after a low stop bit so a break cannot retrigger.
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            dout_q    <= 8'h00;
            par_err_q <= 1'b0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            par_err_q <= par_err_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign rx.dout        = dout_q;
    assign rx.data_strobe = strobe_q;
    assign rx.busy        = busy_q;
    assign rx.rx_error    = err_q;
    assign rx.state       = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one serial line feeds an even-parity and an odd-parity
// receiver; every frame's expected byte/error per receiver is queued up front.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int B      = CLK_HZ / BAUD;

    logic   clk     = 1'b0;
    logic   rst     = 1'b0;
    logic   rx_line = 1'b1;
    int     tests   = 0;
    int     fails   = 0;
    longint cyc     = 0;

    logic [8:0] exp_e[$];
    logic [8:0] exp_o[$];
    logic [8:0] got_e, got_o;
    int         strobes_e = 0;
    int         strobes_o = 0;
    longint     last_strobe_e = 0;
    logic       busy_seen_e = 1'b0;
    logic [7:0] bytes [20];

    uart_rx_if if_e();
    uart_rx_if if_o();
    assign if_e.rx_in = rx_line;
    assign if_o.rx_in = rx_line;

    uart_rx #(.CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .PARITY(0)) dut_e (
        .clk (clk), .rst (rst), .rx (if_e.master));
    uart_rx #(.CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .PARITY(1)) dut_o (
        .clk (clk), .rst (rst), .rx (if_o.master));

    // Clock / reset-independent watchdog
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: expected {rx_error, byte} from the bits placed on the line.
    function automatic logic [8:0] model(input logic [7:0] d, input logic p,
                                         input logic stop, input logic odd);
        int   ones;
        logic want;
        ones = $countones(d);
        want = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return {(p != want) || !stop, d};
    endfunction

    function automatic logic even_par(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    // Scoreboard: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (if_e.busy === 1'b1) busy_seen_e = 1'b1;
        if (if_e.data_strobe === 1'b1) begin
            strobes_e++;
            last_strobe_e = cyc;
            if (exp_e.size() == 0) check("unexpected_strobe_e", 32'd1, 32'd0);
            else begin
                got_e = exp_e.pop_front();
                check("frame_even", {23'd0, if_e.rx_error, if_e.dout}, {23'd0, got_e});
            end
        end
        if (if_o.data_strobe === 1'b1) begin
            strobes_o++;
            if (exp_o.size() == 0) check("unexpected_strobe_o", 32'd1, 32'd0);
            else begin
                got_o = exp_o.pop_front();
                check("frame_odd", {23'd0, if_o.rx_error, if_o.dout}, {23'd0, got_o});
            end
        end
    end

    // Driver tasks
    task automatic hold(input logic v, input int n);
        rx_line = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        exp_e.push_back(model(d, p, stop, PARITY_EVEN));
        exp_o.push_back(model(d, p, stop, PARITY_ODD));
        hold(1'b0, B);
        for (int i = 0; i < 8; i++) hold(d[i], B);
        hold(p, B);
        hold(stop, B);
    endtask

    initial begin
        int         se, so;
        longint     start_cyc;
        logic [7:0] saved;

        // Reset held while the line toggles
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_line = 1'($urandom_range(0, 1));
            #1;
            check("reset_out_e", {21'd0, if_e.dout, if_e.data_strobe, if_e.busy, if_e.rx_error}, 32'd0);
            check("reset_out_o", {21'd0, if_o.dout, if_o.data_strobe, if_o.busy, if_o.rx_error}, 32'd0);
        end
        @(negedge clk);
        rx_line = 1'b1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // First frame 0xA5 with latency check
        se = strobes_e;
        start_cyc = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        hold(1'b1, 2);
        check("a5_one_strobe", strobes_e - se, 32'd1);
        check("a5_latency", 32'((last_strobe_e - start_cyc >= 10 * B) &&
                                (last_strobe_e - start_cyc <= 11 * B)), 32'd1);

        // Random bytes with even-correct parity, then odd-correct parity
        for (int i = 0; i < 20; i++) begin
            bytes[i] = 8'($urandom_range(0, 255));
            send_frame(bytes[i], even_par(bytes[i]), 1'b1);
            hold(1'b1, $urandom_range(0, 30));
        end
        for (int i = 0; i < 20; i++) begin
            send_frame(bytes[i], ~even_par(bytes[i]), 1'b1);
            hold(1'b1, $urandom_range(0, 30));
        end
        hold(1'b1, 4);

        // Glitch shorter than half a bit
        saved = if_e.dout;
        se = strobes_e;
        so = strobes_o;
        busy_seen_e = 1'b0;
        hold(1'b0, B / 4);
        hold(1'b1, 2 * B);
        check("glitch_busy_pulse", {31'd0, busy_seen_e}, 32'd1);
        check("glitch_busy_low", {31'd0, if_e.busy}, 32'd0);
        check("glitch_no_strobe", (strobes_e - se) + (strobes_o - so), 32'd0);
        check("glitch_dout_hold", {24'd0, if_e.dout}, {24'd0, saved});

        // Parity error then a good frame
        send_frame(8'h3C, 1'b1, 1'b1);
        hold(1'b1, 4);
        check("parity_err_flag", {31'd0, if_e.rx_error}, 32'd1);
        check("parity_err_dout", {24'd0, if_e.dout}, 32'h3C);
        send_frame(8'h55, 1'b0, 1'b1);
        hold(1'b1, 4);
        check("parity_ok_flag", {31'd0, if_e.rx_error}, 32'd0);

        // Framing error / break
        send_frame(8'hFF, 1'b0, 1'b0);
        hold(1'b0, 2 * B);
        check("break_busy_e", {31'd0, if_e.busy}, 32'd1);
        check("break_busy_o", {31'd0, if_o.busy}, 32'd1);
        check("break_err", {31'd0, if_e.rx_error}, 32'd1);
        hold(1'b1, 6);
        check("break_release_e", {31'd0, if_e.busy}, 32'd0);
        check("break_release_o", {31'd0, if_o.busy}, 32'd0);
        send_frame(8'h12, 1'b0, 1'b1);
        hold(1'b1, 4);
        check("after_break_dout", {24'd0, if_e.dout}, 32'h12);

        // Reset during data bit 4
        se = strobes_e;
        so = strobes_o;
        hold(1'b0, B);
        for (int i = 0; i < 4; i++) hold(1'b0, B);
        hold(1'b1, B / 2);
        rst = 1'b0;
        #1;
        check("midreset_busy_e", {31'd0, if_e.busy}, 32'd0);
        check("midreset_busy_o", {31'd0, if_o.busy}, 32'd0);
        #19;
        rx_line = 1'b1;
        rst = 1'b1;
        hold(1'b1, 12 * B);
        check("midreset_no_strobe", (strobes_e - se) + (strobes_o - so), 32'd0);
        check("midreset_dout", {24'd0, if_e.dout}, 32'h00);
        send_frame(8'h81, 1'b0, 1'b1);
        hold(1'b1, 2 * B);
        check("after_reset_dout", {24'd0, if_e.dout}, 32'h81);

        // Final report
        check("queue_empty_e", exp_e.size(), 32'd0);
        check("queue_empty_o", exp_o.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
